// File: rtl/text_scroll_ctrl.sv
// Marquee engine: reads a LENGTH-byte string from character memory and streams WINDOW-char
// frames over valid/ready, shifting the frame one character per step (one-shot or wrap).
module text_scroll_ctrl #(
    parameter int         ADDR_WIDTH  = 11,
    parameter int         LEN_WIDTH   = 11,
    parameter int         WINDOW      = 16,
    parameter int         MEM_LATENCY = 1,
    parameter logic [7:0] PAD_CHAR    = 8'h20,
    localparam int        POS_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  mode,
    input  logic                  step,
    input  logic                  stop,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic [7:0]            char_data,
    output logic [POS_W-1:0]      char_pos,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  frame_done,
    output logic                  done,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_HOLD
    } state_t;

    // Index carries one extra bit so one-shot padding positions never alias back into the string.
    localparam int               IDX_W    = LEN_WIDTH + 1;
    localparam int               SUM_W    = (ADDR_WIDTH > IDX_W) ? ADDR_WIDTH : IDX_W;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WINDOW - 1);
    localparam logic [1:0]       LAT_LAST = 2'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] WIN_EXT  = IDX_W'(WINDOW);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   mode_q, mode_d;
    logic [LEN_WIDTH-1:0]   offset_q, offset_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic [7:0]             char_q, char_d;
    logic [1:0]             lat_q, lat_d;
    logic                   done_q, done_d;
    logic                   frame_done_q, frame_done_d;

    logic [IDX_W-1:0]       len_ext;
    logic [IDX_W-1:0]       idx_inc;
    logic [IDX_W-1:0]       index_next;
    logic [LEN_WIDTH-1:0]   off_inc;
    logic [LEN_WIDTH-1:0]   offset_next;
    logic                   oneshot_end;
    logic                   pad_pos;

    assign len_ext     = {1'b0, len_q};
    assign idx_inc     = index_q + IDX_W'(1);
    assign index_next  = (mode_q && (idx_inc == len_ext)) ? '0 : idx_inc;
    assign off_inc     = offset_q + LEN_WIDTH'(1);
    assign offset_next = (mode_q && (off_inc == len_q)) ? '0 : off_inc;
    assign oneshot_end = (({1'b0, offset_q} + WIN_EXT) >= len_ext);
    assign pad_pos     = (index_q >= len_ext);

    assign rd_addr    = ADDR_WIDTH'(SUM_W'(base_q) + SUM_W'(index_q));
    assign char_data  = char_q;
    assign char_pos   = pos_q;
    assign done       = done_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        mode_d       = mode_q;
        offset_d     = offset_q;
        index_d      = index_q;
        pos_d        = pos_q;
        char_d       = char_q;
        lat_d        = lat_q;
        done_d       = 1'b0;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;
        char_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = mem_addr;
                    len_d    = length;
                    mode_d   = mode;
                    offset_d = '0;
                    index_d  = '0;
                    pos_d    = '0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (pad_pos) begin
                    // Only reachable in one-shot mode: wrap mode keeps index below length.
                    char_d  = PAD_CHAR;
                    state_d = S_PRESENT;
                end else begin
                    rd_en   = 1'b1;
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (lat_q == LAT_LAST) begin
                    char_d  = rd_data;
                    state_d = S_PRESENT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            S_PRESENT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    char_valid = 1'b1;
                    if (char_ready) begin
                        if (pos_q == POS_LAST) begin
                            frame_done_d = 1'b1;
                            state_d      = S_HOLD;
                        end else begin
                            pos_d   = pos_q + POS_W'(1);
                            index_d = index_next;
                            state_d = S_FETCH;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    if (!mode_q && oneshot_end) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        offset_d = offset_next;
                        index_d  = {1'b0, offset_next};
                        pos_d    = '0;
                        state_d  = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            mode_q       <= 1'b0;
            offset_q     <= '0;
            index_q      <= '0;
            pos_q        <= '0;
            char_q       <= '0;
            lat_q        <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            mode_q       <= mode_d;
            offset_q     <= offset_d;
            index_q      <= index_d;
            pos_q        <= pos_d;
            char_q       <= char_d;
            lat_q        <= lat_d;
            done_q       <= done_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/text_scroll_ctrl.md
Name: text_scroll_ctrl

Overview:
- Parametrised marquee engine for the UI text path.
- Reads a string of LENGTH bytes from character memory starting at a base address.
- Streams a WINDOW-character frame to the display driver with a valid/ready handshake, then advances the frame offset by one character per step pulse.
- Supports one-shot mode (scroll to end, then signal done) and wrap mode (circular marquee until stop). Sits between the text ROM/RAM and the character display driver.

Parameters:
ADDR_WIDTH, 11, width of memory address and base address
LEN_WIDTH, 11, width of string length and offset counters
WINDOW, 16, characters per frame (>=1)
MEM_LATENCY, 1, cycles from rd_en to valid rd_data (1 or 2)
PAD_CHAR, 8'h20, byte emitted for positions past end of string in one-shot mode

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  pulse; latches mem_addr, length, mode; ignored while busy=1
mem_addr  in  ADDR_WIDTH  base address of string
length  in  LEN_WIDTH  string length in bytes
mode  in  1  0 = one-shot, 1 = wrap
step  in  1  scroll tick pulse; honoured only in HOLD
stop  in  1  abort; return to IDLE next cycle, no done
rd_en  out  1  memory read strobe, one cycle per fetch
rd_addr  out  ADDR_WIDTH  base + index, modulo 2^ADDR_WIDTH
rd_data  in  8  memory read data
char_data  out  8  character for current position
char_pos  out  clog2(WINDOW) (min 1)  position within frame, 0..WINDOW-1
char_valid  out  1  char_data/char_pos valid
char_ready  in  1  driver accepts when char_valid && char_ready
frame_done  out  1  one-cycle pulse after position WINDOW-1 accepted
done  out  1  one-cycle pulse when one-shot scroll completes
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE; offset=0, index=0, pos=0; all outputs 0 (rd_addr=0, char_data=0).
- States: IDLE, FETCH, WAIT, PRESENT, HOLD.
- IDLE:
  - start=1 latches inputs, sets offset=0, pos=0, index=0, and goes to FETCH.
  - start with length=0: done pulses next cycle, state stays IDLE, no frame is emitted.
- FETCH (index<length):
  - Asserts rd_en for exactly one cycle with rd_addr=base+index, then goes to WAIT.
  - One-shot with index>=length: no read; loads PAD_CHAR and goes directly to PRESENT.
- WAIT: counts MEM_LATENCY-1 further cycles, samples rd_data into char_data on the cycle rd_data is valid, then goes to PRESENT. char_valid rises the cycle after sampling.
- PRESENT:
  - char_valid=1, with char_data and char_pos held stable until char_ready.
  - On accept: if pos==WINDOW-1, pulse frame_done and go to HOLD.
  - Otherwise pos++, advance index, and go to FETCH.
- Index advance:
  - Wrap mode: index = (index+1==length) ? 0 : index+1. Frames wrap even when length<WINDOW.
  - One-shot mode: index+1 with no wrap. Positions past the end produce PAD_CHAR.
- HOLD: char_valid=0; waits for step.
  - On step in one-shot mode: if offset+WINDOW>=length, pulse done and go to IDLE.
  - Otherwise (one-shot) offset++.
  - Wrap mode: offset = (offset+1==length) ? 0 : offset+1.
  - Then pos=0, index=offset, and go to FETCH.
- step outside HOLD is ignored; it is not queued.
- stop has priority over every other input in every non-IDLE state: next state IDLE, char_valid=0, rd_en=0, no done or frame_done.
- start has priority over stop in IDLE only.
- Arithmetic:
  - offset+WINDOW is computed at LEN_WIDTH+1 bits, so there is no overflow.
  - rd_addr is truncated to ADDR_WIDTH, so base+index wraps around the memory.
- Throughput: one character per 2+MEM_LATENCY cycles when char_ready is held high.
- Async reset mid-frame: all outputs drop immediately. The next start begins a fresh frame at offset 0.

Test Plan:
- One-shot, MEM_LATENCY=1, WINDOW=4, base=0x010, length=6, memory "ABCDEF", char_ready=1:
  - Frame 0 is ABCD with char_pos 0..3 and frame_done once.
  - Steps produce BCDE, then CDEF.
  - The third step pulses done, busy drops, and no fourth frame is emitted.
- Padding, one-shot, WINDOW=4, length=2 "HI": frame is H,I,0x20,0x20, with rd_en pulsed exactly twice. The first step pulses done.
- Wrap mode, WINDOW=4, length=3 "XYZ":
  - Frame 0 is XYZX, frame after step 1 is YZXY, frame after step 2 is ZXYZ.
  - After step 3, offset returns to 0 (XYZX). done is never asserted.
- Backpressure, MEM_LATENCY=2: hold char_ready=0 for 5 cycles at pos 1. char_valid, char_data and char_pos stay stable, no extra rd_en occurs, and the sequence resumes correctly.
- Edge cases:
  - length=0 start: done pulses next cycle and no rd_en is issued.
  - start while busy: ignored, latched base unchanged.
  - rd_addr wrap: base=0x7FE, length=4 gives rd_addr 0x7FE, 0x7FF, 0x000, 0x001.
- Abort and reset:
  - stop asserted in WAIT: IDLE next cycle, with no done or frame_done.
  - Async reset asserted mid-PRESENT, off a clock edge: char_valid and busy drop immediately.
  - A following start emits frame 0 from offset 0.
